// File: rtl/matrix_3x3_gen_8bit_pkg.sv
// Shared video definitions for the 3x3 window generator and the filters that use it.
package matrix_3x3_gen_8bit_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 11;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    IN_FRAME   = 1'b1
  } frame_state_t;

endpackage

// File: rtl/matrix_3x3_gen_8bit_sync_delay_line.sv
// N-stage register chain used to keep sync strobes aligned with pipelined pixel data.
module sync_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] source,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift the chain by one stage per clock; everything clears on reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= source;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/matrix_3x3_gen_8bit.sv
// Builds a registered 3x3 pixel window from the live stream and two line-RAM taps,
// delays the frame syncs to match, and flags windows lying fully inside the image.
module matrix_3x3_gen_8bit #(
  parameter int DATA_W = matrix_3x3_gen_8bit_pkg::DATA_W,
  parameter int CNT_W  = matrix_3x3_gen_8bit_pkg::CNT_W
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] shiftin,
  input  logic [DATA_W-1:0] taps0x,
  input  logic [DATA_W-1:0] taps1x,
  output logic              matrix_frame_vsync,
  output logic              matrix_frame_href,
  output logic              matrix_frame_clken,
  output logic              matrix_window_valid,
  output logic [DATA_W-1:0] matrix_p11,
  output logic [DATA_W-1:0] matrix_p12,
  output logic [DATA_W-1:0] matrix_p13,
  output logic [DATA_W-1:0] matrix_p21,
  output logic [DATA_W-1:0] matrix_p22,
  output logic [DATA_W-1:0] matrix_p23,
  output logic [DATA_W-1:0] matrix_p31,
  output logic [DATA_W-1:0] matrix_p32,
  output logic [DATA_W-1:0] matrix_p33
);

  import matrix_3x3_gen_8bit_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

  logic              vsync_d1;
  logic              href_d1;
  logic              clken_d1;
  logic [DATA_W-1:0] shiftin_d1;
  logic              vsync_armed;
  logic              vsync_rise;
  logic              vsync_fall;
  logic              href_fall;
  logic [CNT_W-1:0]  col_cnt;
  logic [CNT_W-1:0]  row_cnt;
  logic [CNT_W-1:0]  col_now;
  frame_state_t      state;
  frame_state_t      state_next;

  // Stage 1 lines the syncs up with the taps, which arrive one cycle after shiftin.
  sync_delay_line #(.WIDTH(3), .DEPTH(1)) u_stage1 (
    .clock   (clock),
    .rst_n   (rst_n),
    .source  ({per_frame_vsync, per_frame_href, per_frame_clken}),
    .delayed ({vsync_d1, href_d1, clken_d1})
  );

  // Stage 2 matches the window register, so the sync outputs describe the window on display.
  sync_delay_line #(.WIDTH(3), .DEPTH(1)) u_stage2 (
    .clock   (clock),
    .rst_n   (rst_n),
    .source  ({vsync_d1, href_d1, clken_d1}),
    .delayed ({matrix_frame_vsync, matrix_frame_href, matrix_frame_clken})
  );

  // Register the live pixel so it lines up with the one-cycle-late taps.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) shiftin_d1 <= '0;
    else        shiftin_d1 <= shiftin;
  end

  // A frame start only counts once vsync has been seen low, so reset mid-frame cannot fake a rise.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                vsync_armed <= 1'b0;
    else if (!per_frame_vsync) vsync_armed <= 1'b1;
  end

  assign vsync_rise = vsync_armed & vsync_d1 & ~matrix_frame_vsync;
  assign vsync_fall = ~vsync_d1 & matrix_frame_vsync;
  assign href_fall  = ~href_d1 & matrix_frame_href;
  assign col_now    = href_d1 ? col_cnt : '0;

  // Frame state register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= WAIT_FRAME;
    else        state <= state_next;
  end

  // Enter the frame on a vsync rise, leave it on a vsync fall.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_FRAME: if (vsync_rise) state_next = IN_FRAME;
      IN_FRAME:   if (vsync_fall) state_next = WAIT_FRAME;
      default:    state_next = WAIT_FRAME;
    endcase
  end

  // Column index of the pixel entering p33; counts strobes inside a line and saturates.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                              col_cnt <= '0;
    else if (!href_d1)                       col_cnt <= '0;
    else if (clken_d1 && col_cnt != CNT_MAX) col_cnt <= col_cnt + CNT_ONE;
  end

  // Row index within the frame; a frame start wins over a line end in the same cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                              row_cnt <= '0;
    else if (vsync_rise)                     row_cnt <= '0;
    else if (href_fall && row_cnt != CNT_MAX) row_cnt <= row_cnt + CNT_ONE;
  end

  // Shift every window row left by one column on each aligned pixel strobe.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      matrix_p11 <= '0; matrix_p12 <= '0; matrix_p13 <= '0;
      matrix_p21 <= '0; matrix_p22 <= '0; matrix_p23 <= '0;
      matrix_p31 <= '0; matrix_p32 <= '0; matrix_p33 <= '0;
    end else if (clken_d1) begin
      matrix_p11 <= matrix_p12; matrix_p12 <= matrix_p13; matrix_p13 <= taps1x;
      matrix_p21 <= matrix_p22; matrix_p22 <= matrix_p23; matrix_p23 <= taps0x;
      matrix_p31 <= matrix_p32; matrix_p32 <= matrix_p33; matrix_p33 <= shiftin_d1;
    end
  end

  // Validity is registered with the window: only full interior neighbourhoods qualify.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) matrix_window_valid <= 1'b0;
    else        matrix_window_valid <= (state == IN_FRAME) && clken_d1 &&
                                       (row_cnt >= CNT_TWO) && (col_now >= CNT_TWO);
  end

endmodule

// File: tb/tb_matrix_3x3_gen_8bit.sv
// Scoreboard bench for the 3x3 window generator: a default instance plus a CNT_W=3 instance.
module tb_matrix_3x3_gen_8bit;

  typedef struct packed {
    logic        valid;
    logic        valid_sat;
    logic [71:0] window;
  } exp_t;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       per_frame_vsync = 1'b0;
  logic       per_frame_href = 1'b0;
  logic       per_frame_clken = 1'b0;
  logic [7:0] shiftin = 8'h00;
  logic [7:0] taps0x = 8'h00;
  logic [7:0] taps1x = 8'h00;

  logic       matrix_frame_vsync, matrix_frame_href, matrix_frame_clken, matrix_window_valid;
  logic [7:0] win [9];
  logic       sat_vsync, sat_href, sat_clken, sat_valid;
  logic [7:0] sat_win [9];

  exp_t       sb_q [$];
  exp_t       mon_e;
  int         total = 0;
  int         bad = 0;

  int         model_row = 0;
  int         model_col = 0;
  bit         frame_ok = 1'b0;
  bit         prev_vs = 1'b0;
  bit         prev_hr = 1'b0;
  logic [7:0] img [16][16];
  logic [7:0] line0 [16];
  logic [7:0] line1 [16];
  logic [7:0] tap0_pend = 8'h00;
  logic [7:0] tap1_pend = 8'h00;

  always #5 clock = ~clock;

  matrix_3x3_gen_8bit dut (
    .clock(clock), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .shiftin(shiftin), .taps0x(taps0x), .taps1x(taps1x),
    .matrix_frame_vsync(matrix_frame_vsync), .matrix_frame_href(matrix_frame_href),
    .matrix_frame_clken(matrix_frame_clken), .matrix_window_valid(matrix_window_valid),
    .matrix_p11(win[0]), .matrix_p12(win[1]), .matrix_p13(win[2]),
    .matrix_p21(win[3]), .matrix_p22(win[4]), .matrix_p23(win[5]),
    .matrix_p31(win[6]), .matrix_p32(win[7]), .matrix_p33(win[8])
  );

  matrix_3x3_gen_8bit #(.CNT_W(3)) dut_sat (
    .clock(clock), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .shiftin(shiftin), .taps0x(taps0x), .taps1x(taps1x),
    .matrix_frame_vsync(sat_vsync), .matrix_frame_href(sat_href),
    .matrix_frame_clken(sat_clken), .matrix_window_valid(sat_valid),
    .matrix_p11(sat_win[0]), .matrix_p12(sat_win[1]), .matrix_p13(sat_win[2]),
    .matrix_p21(sat_win[3]), .matrix_p22(sat_win[4]), .matrix_p23(sat_win[5]),
    .matrix_p31(sat_win[6]), .matrix_p32(sat_win[7]), .matrix_p33(sat_win[8])
  );

  function automatic logic [71:0] pack_win(input logic [7:0] w [9]);
    return {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7], w[8]};
  endfunction

  function automatic int sat7(input int x);
    return (x > 7) ? 7 : x;
  endfunction

  function automatic logic [7:0] pixel_at(input logic [7:0] base, input int r, input int c);
    return base + 8'(16 * r + c);
  endfunction

  task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // One cycle of stimulus: drive inputs, feed the line-RAM model, push the expected window.
  task automatic applyStimulus(input logic vs, input logic hr, input logic ck, input logic [7:0] pix);
    exp_t e;
    int   ec;
    @(posedge clock);
    #1;
    taps0x = tap0_pend;
    taps1x = tap1_pend;
    per_frame_vsync = vs;
    per_frame_href = hr;
    per_frame_clken = ck;
    shiftin = pix;
    ec = hr ? model_col : 0;
    if (ck) begin
      if (hr) begin
        img[model_row & 15][ec] = pix;
        tap0_pend = line0[ec];
        tap1_pend = line1[ec];
        line1[ec] = line0[ec];
        line0[ec] = pix;
      end
      e.valid = frame_ok && (model_row >= 2) && (ec >= 2);
      e.valid_sat = frame_ok && (sat7(model_row) >= 2) && (sat7(ec) >= 2);
      e.window = '0;
      if (e.valid) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.window[71 - 8 * (3 * i + j) -: 8] = img[(model_row - 2 + i) & 15][ec - 2 + j];
      end
      sb_q.push_back(e);
    end
    if (!hr) model_col = 0;
    else if (ck) model_col++;
    if (vs && !prev_vs) model_row = 0;
    else if (!hr && prev_hr) model_row++;
    if (vs && !prev_vs) frame_ok = 1'b1;
    else if (!vs && prev_vs) frame_ok = 1'b0;
    prev_vs = vs;
    prev_hr = hr;
  endtask

  task automatic run_line(input logic vs, input int r, input int cols, input bit gapped, input logic [7:0] base);
    for (int c = 0; c < cols; c++) begin
      if (gapped && (c % 3 == 1)) applyStimulus(vs, 1'b1, 1'b0, 8'h00);
      applyStimulus(vs, 1'b1, 1'b1, pixel_at(base, r, c));
    end
    applyStimulus(vs, 1'b0, 1'b0, 8'h00);
    if (gapped) applyStimulus(vs, 1'b0, 1'b1, 8'hEE);
    applyStimulus(vs, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic run_frame(input int rows, input int cols, input bit gapped, input logic [7:0] base);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int r = 0; r < rows; r++) run_line(1'b1, r, cols, gapped, base);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Compare every produced window against the oldest expectation.
  always @(negedge clock) begin
    if (rst_n === 1'b1 && matrix_frame_clken === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $error("[TB] FAIL sb_underflow observed=window_out expected=none_pending");
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("valid", 72'(matrix_window_valid), 72'(mon_e.valid));
        checkOutput("valid_sat", 72'(sat_valid), 72'(mon_e.valid_sat));
        if (mon_e.valid) checkOutput("window", pack_win(win), mon_e.window);
        if (mon_e.valid_sat) checkOutput("window_sat", pack_win(sat_win), mon_e.window);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      line0[i] = 8'h00;
      line1[i] = 8'h00;
      for (int j = 0; j < 16; j++) img[i][j] = 8'h00;
    end

    repeat (2) @(negedge clock);
    checkOutput("reset_ctrl", 72'({matrix_frame_vsync, matrix_frame_href, matrix_frame_clken, matrix_window_valid}), 72'(0));
    checkOutput("reset_win", pack_win(win), 72'(0));
    checkOutput("reset_sat_ctrl", 72'({sat_vsync, sat_href, sat_clken, sat_valid}), 72'(0));
    rst_n = 1'b1;
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, (k == 0), 8'hA5);
      @(negedge clock);
      checkOutput("clken_latency", 72'(matrix_frame_clken), 72'(k == 2));
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clock);
      checkOutput("vsync_rise_latency", 72'(matrix_frame_vsync), 72'(k == 2));
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      @(negedge clock);
      checkOutput("href_rise_latency", 72'(matrix_frame_href), 72'(k == 2));
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clock);
      checkOutput("href_fall_latency", 72'(matrix_frame_href), 72'(k != 2));
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      @(negedge clock);
      checkOutput("vsync_fall_latency", 72'(matrix_frame_vsync), 72'(k != 2));
    end

    $display("[TB] dense 8x4 frame");
    run_frame(4, 8, 1'b0, 8'h00);

    $display("[TB] gapped clken frame");
    run_frame(4, 8, 1'b1, 8'h60);

    $display("[TB] frame restart mid-image");
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int r = 0; r < 3; r++) run_line(1'b1, r, 8, 1'b0, 8'h00);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 8; c++) applyStimulus(1'b0, 1'b1, 1'b1, pixel_at(8'h80, 0, c));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int r = 0; r < 4; r++) run_line(1'b1, r, 8, 1'b0, 8'h40);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

    $display("[TB] reset mid-stream");
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    run_line(1'b1, 0, 8, 1'b0, 8'h30);
    run_line(1'b1, 1, 8, 1'b0, 8'h30);
    for (int c = 0; c < 5; c++) applyStimulus(1'b1, 1'b1, 1'b1, pixel_at(8'h30, 2, c));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_ctrl", 72'({matrix_frame_vsync, matrix_frame_href, matrix_frame_clken, matrix_window_valid}), 72'(0));
    checkOutput("midreset_win", pack_win(win), 72'(0));
    checkOutput("midreset_sat_ctrl", 72'({sat_vsync, sat_href, sat_clken, sat_valid}), 72'(0));
    sb_q.delete();
    model_row = 0;
    model_col = 0;
    frame_ok = 1'b0;
    prev_hr = 1'b0;
    prev_vs = 1'b1;
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    #2 rst_n = 1'b1;
    for (int c = 5; c < 8; c++) applyStimulus(1'b1, 1'b1, 1'b1, pixel_at(8'h30, 2, c));
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    run_line(1'b1, 3, 8, 1'b0, 8'h30);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    run_frame(4, 8, 1'b0, 8'h50);

    $display("[TB] long line for counter saturation");
    run_frame(3, 12, 1'b0, 8'h08);

    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("sb_drain", 72'(sb_q.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_3x3_gen_8bit.md
Name: matrix_3x3_gen_8bit

Overview:
- Consumer side of the 8-bit line-shift RAM interface.
- Takes the live pixel stream plus the two delayed line taps and assembles a registered 3x3 pixel window for downstream neighbourhood filters (Sobel, median, Gaussian).
- Delays the frame sync signals to stay aligned with the window.
- Flags which windows lie fully inside the image.

Parameters:
- DATA_W, 8, pixel width for all data ports.
- CNT_W, 11, width of the internal row and column counters; counters saturate at 2^CNT_W-1.

Ports:
- clock  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- per_frame_vsync  input  1  frame sync, high during the active frame.
- per_frame_href  input  1  line valid.
- per_frame_clken  input  1  pixel strobe for shiftin.
- shiftin  input  DATA_W  current-row pixel, valid with per_frame_clken at cycle t.
- taps0x  input  DATA_W  previous-row pixel for the same column, valid at cycle t+1.
- taps1x  input  DATA_W  row-before-previous pixel for the same column, valid at cycle t+1.
- matrix_frame_vsync  output  1  vsync delayed 2 cycles.
- matrix_frame_href  output  1  href delayed 2 cycles.
- matrix_frame_clken  output  1  clken delayed 2 cycles; window updated this cycle.
- matrix_window_valid  output  1  window fully inside the image.
- matrix_p11, p12, p13  output  DATA_W each  oldest row (taps1x), left to right.
- matrix_p21, p22, p23  output  DATA_W each  middle row (taps0x).
- matrix_p31, p32, p33  output  DATA_W each  current row (shiftin).

Behaviour:
- Reset (async, rst_n low): all outputs, shift registers, counters and delay lines go to 0; FSM goes to WAIT_FRAME.
- Alignment:
  - shiftin, clken, href and vsync are registered once (stage 1), matching the 1-cycle tap latency.
  - Stage-1 clken is the shift enable.
- Window shift: on each edge where stage-1 clken is high, each row shifts left by one column.
  - p11<=p12, p12<=p13, p13<=taps1x.
  - p21<=p22, p22<=p23, p23<=taps0x.
  - p31<=p32, p32<=p33, p33<=shiftin_d1.
  - With stage-1 clken low, the window holds.
- Latency: an input pixel at cycle t appears in p33 and raises matrix_frame_clken at cycle t+2. The sync outputs carry the same 2-cycle delay.
- Column counter col_cnt:
  - increments on each shift while stage-1 href is high;
  - cleared whenever stage-1 href is low;
  - its value is the column index of the pixel now in p33.
- Row counter row_cnt:
  - increments on each stage-1 href falling edge;
  - cleared on a stage-1 vsync rising edge.
- Both counters saturate; they never wrap.
- FSM:
  - WAIT_FRAME -> IN_FRAME on a stage-1 vsync rising edge.
  - IN_FRAME -> WAIT_FRAME on a stage-1 vsync falling edge.
  - In WAIT_FRAME, matrix_window_valid is forced low. A reset mid-frame therefore suppresses validity until the next full frame.
- matrix_window_valid is high only when all hold: IN_FRAME, matrix_frame_clken=1, row_cnt>=2, col_cnt>=2. It is registered together with the window.
- Border pixels (rows 0-1, columns 0-1) still shift and output with valid=0. No replication or zero padding.
- Simultaneous events:
  - vsync rise and href fall on the same stage-1 edge: row_cnt clears; the clear wins.
  - href low with clken high: the window still shifts, col_cnt stays 0, valid stays 0.
- Window contents are not cleared between lines or frames. Only valid gates their use.

Decomposition:
- Shared video package holds:
  - DATA_W default;
  - CNT_W default;
  - the FSM state encoding (WAIT_FRAME=1'b0, IN_FRAME=1'b1).
- One natural sub-module, sync_delay_line: parameterised N-stage register chain with async active-low reset. It is used for the vsync/href/clken delays and reused by downstream filters to match their latencies.

Test Plan:
- Reset mid-stream: assert rst_n=0 during an active line -> all outputs 0 in the same cycle; matrix_window_valid stays 0 until the second line after the next vsync rise.
- 8x4 frame, pixel = 16*row+col, taps driven from a behavioural 1-cycle-latency line model:
  - row 2, col 2 -> p11..p33 = 00,01,02,10,11,12,20,21,22 hex, valid=1;
  - row 2, col 1 -> valid=0.
- Latency: a single clken pulse at cycle 10 -> matrix_frame_clken high exactly at cycle 12; href/vsync edges shifted by exactly 2 cycles.
- Gapped clken: toggle clken 1-0-1 within a line -> window holds during gaps, col_cnt counts strobes only, and valid windows match the dense-stream reference.
- Frame restart: vsync falls then rises mid-image -> row_cnt restarts at 0; first two rows of the new frame have valid=0.
- Saturation: with CNT_W=3, drive a 12-pixel line -> col_cnt sticks at 7, valid stays 1, no wrap to invalid.
